// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush,
// data-memory miss freeze with timeout, and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [4:0]       IFID_rs1_i,
  input  logic [4:0]       IFID_rs2_i,
  input  logic [4:0]       IDEX_rd_i,
  input  logic             IDEX_MemRead_i,
  input  logic             Branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFID_Stall_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             Freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o
);

  localparam int WAIT_W = (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MISS_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_MISS_WAIT = 2'd2,
    S_ERROR     = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              luh;
  logic              miss;
  logic              timeout;

  assign luh  = IDEX_MemRead_i && (IDEX_rd_i != 5'd0) &&
                ((IDEX_rd_i == IFID_rs1_i) || (IDEX_rd_i == IFID_rs2_i));
  assign miss = mem_req_i && !mem_ack_i;

  // wait_cnt counts completed MISS_WAIT cycles; the timeout fires as it reaches MISS_TIMEOUT
  assign wait_inc = wait_cnt + WAIT_W'(1);
  assign timeout  = (state == S_MISS_WAIT) && !mem_ack_i && (wait_inc == TIMEOUT_V);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start_i) state_nxt = S_RUN;
      S_RUN:       if (miss) state_nxt = S_MISS_WAIT;
      S_MISS_WAIT: begin
        if (mem_ack_i) begin
          state_nxt = S_RUN;
        end else if (timeout) begin
          state_nxt = S_ERROR;
        end
      end
      default:     state_nxt = state;
    endcase
    if (!start_i) state_nxt = S_IDLE;
  end

  always_comb begin
    PCWrite_o     = 1'b0;
    IFID_Stall_o  = 1'b0;
    IFID_Flush_o  = 1'b1;
    IDEX_Bubble_o = 1'b1;
    Freeze_o      = 1'b0;
    case (state)
      S_RUN: begin
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;
        if (miss) begin
          IFID_Stall_o = 1'b1;
          Freeze_o     = 1'b1;
        end else if (luh) begin
          IFID_Stall_o  = 1'b1;
          IDEX_Bubble_o = 1'b1;
        end else if (Branch_taken_i) begin
          PCWrite_o    = 1'b1;
          IFID_Flush_o = 1'b1;
        end else begin
          PCWrite_o = 1'b1;
        end
      end
      S_MISS_WAIT: begin
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;
        if (mem_ack_i) begin
          PCWrite_o = 1'b1;
        end else begin
          IFID_Stall_o = 1'b1;
          Freeze_o     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Leaving MISS_WAIT zeroes the counter, so every entry starts from zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (state == S_MISS_WAIT) begin
      wait_cnt <= wait_inc;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if (IFID_Stall_o && ((state == S_RUN) || (state == S_MISS_WAIT)) && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (IFID_Flush_o && (state == S_RUN) && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
      if (timeout) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the stall and flush event counters.
REQ-002 The block SHALL have parameter MISS_TIMEOUT, default 255, setting the maximum number of MISS_WAIT cycles before an error.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  pipeline enable; low forces IDLE.
REQ-007 IFID_rs1_i  in  5  rs1 of the instruction in ID.
REQ-008 IFID_rs2_i  in  5  rs2 of the instruction in ID.
REQ-009 IDEX_rd_i  in  5  destination register of the instruction in EX.
REQ-010 IDEX_MemRead_i  in  1  instruction in EX is a load.
REQ-011 Branch_taken_i  in  1  branch in ID resolved taken.
REQ-012 mem_req_i  in  1  MEM stage issues a data-memory access this cycle.
REQ-013 mem_ack_i  in  1  data memory completes the access this cycle.
REQ-014 PCWrite_o  out  1  PC register update enable.
REQ-015 IFID_Stall_o  out  1  stall to the IF/ID register.
REQ-016 IFID_Flush_o  out  1  flush to the IF/ID register.
REQ-017 IDEX_Bubble_o  out  1  force the ID/EX control fields to zero (NOP).
REQ-018 Freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-019 stall_cnt_o  out  CNT_W  saturating count of stall cycles.
REQ-020 flush_cnt_o  out  CNT_W  saturating count of flushes.
REQ-021 err_o  out  1  sticky memory-timeout error flag.

Function
REQ-022 The FSM SHALL have the states IDLE, RUN, MISS_WAIT and ERROR, and its state register SHALL update on the rising edge of clk_i.
REQ-023 In any state, start_i=0 SHALL cause the next state to be IDLE; in IDLE, start_i=1 SHALL cause the next state to be RUN.
REQ-024 In IDLE, outputs SHALL be: PCWrite_o=0, IFID_Stall_o=0, IFID_Flush_o=1, IDEX_Bubble_o=1, Freeze_o=0.
REQ-025 The load-use hazard SHALL be computed as luh = IDEX_MemRead_i & (IDEX_rd_i!=0) & (IDEX_rd_i==IFID_rs1_i | IDEX_rd_i==IFID_rs2_i).
REQ-026 A memory miss SHALL be computed as miss = mem_req_i & ~mem_ack_i.
REQ-027 In RUN, outputs SHALL be combinational from the inputs in the same cycle, with priority miss > luh > Branch_taken_i.
REQ-028 In RUN with miss, outputs SHALL be: Freeze_o=1, PCWrite_o=0, IFID_Stall_o=1, IFID_Flush_o=0, IDEX_Bubble_o=0, and the next state SHALL be MISS_WAIT.
REQ-029 In RUN with luh and no miss, outputs SHALL be: PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1, IFID_Flush_o=0; the stall lasts one cycle unless luh persists.
REQ-030 In RUN with Branch_taken_i and neither miss nor luh, outputs SHALL be: IFID_Flush_o=1, PCWrite_o=1, IFID_Stall_o=0, IDEX_Bubble_o=0.
REQ-031 In RUN with none of miss, luh or Branch_taken_i, outputs SHALL be: PCWrite_o=1 and all other control outputs 0.
REQ-032 In MISS_WAIT, outputs SHALL match the RUN miss case (REQ-028), and the wait counter SHALL increment each cycle.
REQ-033 In MISS_WAIT, mem_ack_i=1 SHALL move the next state to RUN, and the outputs in that same cycle SHALL be the RUN no-event values (pipeline advances).
REQ-034 In MISS_WAIT, a wait counter equal to MISS_TIMEOUT without mem_ack_i SHALL move the next state to ERROR and set err_o on that edge.
REQ-035 In ERROR, outputs SHALL be the IDLE values, and the block SHALL leave ERROR only via reset or start_i=0.
REQ-036 err_o SHALL clear only on reset.
REQ-037 The wait counter SHALL be cleared on every entry into MISS_WAIT.
REQ-038 stall_cnt_o SHALL increment on each clock where IFID_Stall_o=1 in RUN or MISS_WAIT.
REQ-039 flush_cnt_o SHALL increment on each clock where IFID_Flush_o=1 in RUN.
REQ-040 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-041 When mem_ack_i coincides with mem_req_i in RUN, the block SHALL treat the access as no miss and SHALL NOT enter MISS_WAIT.

Reset
REQ-042 On rst_ni=0, the block SHALL immediately (asynchronously) set state=IDLE, stall_cnt_o=0, flush_cnt_o=0, wait counter=0 and err_o=0.
REQ-043 A reset asserted mid-MISS_WAIT SHALL abandon the wait with no residual freeze after release.
REQ-044 After rst_ni deasserts, the block SHALL remain in IDLE until start_i=1 is sampled.

Verification
REQ-045 Bench SHALL check load-use: MemRead=1, rd=5, rs1=5 for one cycle -> PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1 for exactly that cycle; stall_cnt_o 0->1.
REQ-046 Bench SHALL check rd=0: MemRead=1, rd=0, rs1=0 -> no stall, PCWrite_o=1.
REQ-047 Bench SHALL check luh+branch: luh with Branch_taken_i=1 -> stall wins, IFID_Flush_o=0; next cycle without luh -> IFID_Flush_o=1, flush_cnt_o increments.
REQ-048 Bench SHALL check a miss: mem_req_i=1, mem_ack_i low for 3 cycles then high -> Freeze_o=1 for 3 cycles, released in the ack cycle; stall_cnt_o=3.
REQ-049 Bench SHALL check timeout: MISS_TIMEOUT=4, ack never given -> err_o=1 after the 4th wait cycle, IDLE outputs held; start_i toggled 0->1 -> RUN with err_o still 1.
REQ-050 Bench SHALL check reset: rst_ni pulsed low mid-MISS_WAIT -> Freeze_o=0 immediately, counters=0, IDLE outputs held.
